mem_pattern_tester: RTL and testbench
=====================================

MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

Interface
REQ-001 Parameter DW, default 16: memory data width; legal values 16 and 32.
REQ-002 Parameter CNT_W, default 32: width of passcount and failcount.
REQ-003 Parameter IDX_W, default 24: beat-index width.
REQ-004 Parameter RST_WAIT, default 5000000: power-up hold cycles before controller release.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 mode  in  2  pattern select: 0 LFSR, 1 walking-one, 2 address, 3 checkerboard.
REQ-008 mem_rst_n  out  1  controller reset; 0 = controller held in reset.
REQ-009 mem_start  out  1  one-cycle pulse that starts a full-array sweep.
REQ-010 mem_rnw  out  1  sweep direction; 1 = read, 0 = write; stable from setup until done.
REQ-011 mem_done  in  1  one-cycle pulse marking sweep (or controller init) complete.
REQ-012 mem_ready  in  1  data beat strobe; one per word.
REQ-013 mem_wdat  out  DW  expected/write pattern for the current beat.
REQ-014 mem_rdat  in  DW  read data, valid when mem_ready=1.
REQ-015 passcount  out  CNT_W  completed write+read passes.
REQ-016 failcount  out  CNT_W  mismatching read beats.
REQ-017 err_valid  out  1; err_idx  out  IDX_W; err_exp, err_act  out  DW  first-error log.

Function
REQ-018 FSM states SHALL be HOLD, INIT, WR_SET, WR_GO, WRITE, RD_SET, RD_GO, READ, PASS_END.
REQ-019 HOLD: mem_rst_n=0; count RST_WAIT cycles; then INIT.
REQ-020 INIT: mem_rst_n=1; wait mem_done; then WR_SET.
REQ-021 WR_SET: latch mode into mode_q; save generator state; mem_rnw=0; next WR_GO.
REQ-022 WR_GO: mem_start=1 for exactly one cycle; next WRITE; WRITE waits mem_done, then RD_SET.
REQ-023 RD_SET: restore generator state; mem_rnw=1; clear beat index; next RD_GO, which pulses mem_start; READ waits mem_done.
REQ-024 PASS_END: passcount+1 (wraps modulo 2^CNT_W); next WR_SET. Pass latency: 2 setup cycles plus sweep per direction, plus 1.
REQ-025 The generator SHALL advance and the beat index SHALL increment on every mem_ready in WRITE and READ; mem_wdat is the pre-advance value.
REQ-026 LFSR: maximal-length DW-bit Galois LFSR, seed 1 at reset; state carries across passes.
REQ-027 Walking-one: starts at 1 each sweep; rotate left 1 per beat.
REQ-028 Address: mem_wdat = beat index zero-extended or truncated to DW.
REQ-029 Checkerboard: alternate 0x5555.. and 0xAAAA.. per beat; starting word inverts every pass.
REQ-030 In READ, a beat with mem_rdat != mem_wdat SHALL increment failcount, saturating at all-ones.
REQ-031 mem_ready and mem_done in the same cycle: the beat is processed, then the transition taken.
REQ-032 Beat index SHALL wrap modulo 2^IDX_W.
REQ-033 mode changes during a pass take effect only at the next WR_SET.
REQ-034 mem_ready outside WRITE or READ SHALL be ignored.

Reset
REQ-035 rst_n=0 at any state, including mid-sweep: next state HOLD; hold counter, passcount, failcount, beat index and err_* cleared; LFSR reseeded.
REQ-036 During reset: mem_rst_n=0, mem_start=0, mem_rnw=0, mem_wdat=0.

Configuration
REQ-037 Macro MEMTEST_ERRLOG_EN defined: on the first mismatch after reset, set err_valid=1 sticky and capture err_idx, err_exp and err_act; later mismatches SHALL NOT overwrite them.
REQ-038 Macro MEMTEST_ERRLOG_EN undefined: err_* tied to 0 and no log registers present; failcount is unaffected.

Verification (RST_WAIT=8, controller model with 16 words)
REQ-039 Reset then clean model, mode=0 -> mem_rst_n rises after 8 cycles; after 3 passes passcount=3, failcount=0.
REQ-040 Model flips bit 0 of word 5 on read, mode=2 -> each pass failcount +1; with the macro, err_idx=5, err_exp=0x0005, err_act=0x0004.
REQ-041 mode=1, DW=32, write sweep -> mem_wdat sequence 0x1, 0x2, 0x4 ... 0x8000; repeated identically on read.
REQ-042 mode=3 -> pass 0 word 0 = 0x5555; pass 1 word 0 = 0xAAAA; no fails.
REQ-043 rst_n low for 1 cycle mid-READ -> next cycle in HOLD, counters 0, mem_start not pulsed until re-init.
REQ-044 Force failcount to all-ones, then a mismatch -> failcount stays all-ones.

Source files
------------

// File: rtl/mem_pattern_tester_if.sv
// Memory-controller handshake bundle: reset, start, direction, beat strobe and data.
// Latency: none (wires only).
// Backpressure: none; the controller paces beats with mem_ready and ends sweeps with mem_done.
//
// Ports (master = tester side):
//   mem_rst_n, mem_start, mem_rnw, mem_wdat  : tester -> controller
//   mem_done, mem_ready, mem_rdat            : controller -> tester
interface mem_pattern_tester_if #(
  parameter int DW = 16
);
  logic          mem_rst_n;
  logic          mem_start;
  logic          mem_rnw;
  logic          mem_done;
  logic          mem_ready;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;

  modport master (
    output mem_rst_n, mem_start, mem_rnw, mem_wdat,
    input  mem_done, mem_ready, mem_rdat
  );

  modport slave (
    input  mem_rst_n, mem_start, mem_rnw, mem_wdat,
    output mem_done, mem_ready, mem_rdat
  );
endinterface

// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: repeated full-array write/read sweeps, counting read-back mismatches.
// Latency: one pass = (2 setup cycles + sweep) per direction + 1; a mismatch is counted 1 cycle after its beat.
// Backpressure: none; a beat is consumed on every mem_ready in WRITE/READ, the controller sets the pace.
//
// Ports: clk; rst_n (synchronous, active-low); mode (0 LFSR, 1 walking-one, 2 address, 3 checkerboard);
//   mem (mem_pattern_tester_if.master); passcount (wrapping); failcount (saturating);
//   err_valid/err_idx/err_exp/err_act: first-mismatch log, built only when MEMTEST_ERRLOG_EN is defined,
//   otherwise tied to 0.
module mem_pattern_tester #(
  parameter int DW       = 16,
  parameter int CNT_W    = 32,
  parameter int IDX_W    = 24,
  parameter int RST_WAIT = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  mem_pattern_tester_if.master mem,
  output logic [CNT_W-1:0]     passcount,
  output logic [CNT_W-1:0]     failcount,
  output logic                 err_valid,
  output logic [IDX_W-1:0]     err_idx,
  output logic [DW-1:0]        err_exp,
  output logic [DW-1:0]        err_act
);

  typedef enum logic [3:0] {
    HOLD, INIT, WR_SET, WR_GO, WRITE, RD_SET, RD_GO, READ, PASS_END
  } state_t;

  localparam int HW = $clog2(RST_WAIT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_WAIT - 1);

  // Galois taps: x^16+x^14+x^13+x^11+1 and x^32+x^22+x^2+x+1 (right-shifting form).
  localparam logic [31:0]   TAPS_FULL = (DW == 32) ? 32'h8020_0003 : 32'h0000_B400;
  localparam logic [DW-1:0] LFSR_TAPS = TAPS_FULL[DW-1:0];
  localparam logic [DW-1:0] CHK_A     = {(DW/2){2'b01}};
  localparam logic [DW-1:0] CHK_B     = {(DW/2){2'b10}};

  state_t            state, state_nx;
  logic [HW-1:0]     hold_cnt;
  logic [1:0]        mode_q;
  logic [DW-1:0]     lfsr_q, lfsr_sv, walk_q, chk_q, pat, idx_pat;
  logic              chk_inv_q;
  logic [IDX_W-1:0]  idx_q;
  logic              start_c, rnw_c, beat, mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HOLD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    rnw_c    = 1'b0;
    case (state)
      HOLD:     if (hold_cnt == HOLD_LAST) state_nx = INIT;
      INIT:     if (mem.mem_done) state_nx = WR_SET;
      WR_SET:   state_nx = WR_GO;
      WR_GO:    begin start_c = 1'b1; state_nx = WRITE; end
      WRITE:    if (mem.mem_done) state_nx = RD_SET;
      RD_SET:   begin rnw_c = 1'b1; state_nx = RD_GO; end
      RD_GO:    begin rnw_c = 1'b1; start_c = 1'b1; state_nx = READ; end
      READ:     begin rnw_c = 1'b1; if (mem.mem_done) state_nx = PASS_END; end
      PASS_END: state_nx = WR_SET;
      default:  state_nx = HOLD;
    endcase
  end

  // Address pattern: beat index zero-extended or truncated to the data width.
  if (IDX_W >= DW) begin : g_idx_trunc
    assign idx_pat = idx_q[DW-1:0];
  end else begin : g_idx_ext
    assign idx_pat = {{(DW-IDX_W){1'b0}}, idx_q};
  end

  always_comb begin
    pat = lfsr_q;
    case (mode_q)
      2'd1:    pat = walk_q;
      2'd2:    pat = idx_pat;
      2'd3:    pat = chk_q;
      default: pat = lfsr_q;
    endcase
  end

  // Beats are only meaningful inside a sweep; strobes elsewhere are dropped.
  assign beat     = mem.mem_ready && (state == WRITE || state == READ);
  assign mismatch = beat && (state == READ) && (mem.mem_rdat != pat);

  // Outputs are forced low while rst_n is asserted, independent of the state register.
  assign mem.mem_rst_n = rst_n && (state != HOLD);
  assign mem.mem_start = rst_n && start_c;
  assign mem.mem_rnw   = rst_n && rnw_c;
  assign mem.mem_wdat  = rst_n ? pat : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      mode_q    <= 2'd0;
      lfsr_q    <= DW'(1);
      lfsr_sv   <= DW'(1);
      walk_q    <= DW'(1);
      chk_q     <= CHK_A;
      chk_inv_q <= 1'b0;
      idx_q     <= '0;
      passcount <= '0;
      failcount <= '0;
    end else begin
      if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
      if (beat) begin
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        walk_q <= {walk_q[DW-2:0], walk_q[DW-1]};
        chk_q  <= ~chk_q;
        idx_q  <= idx_q + IDX_W'(1);
      end
      if (mismatch && (failcount != {CNT_W{1'b1}})) failcount <= failcount + CNT_W'(1);
      case (state)
        WR_SET: begin
          // The LFSR snapshot lets the read sweep regenerate exactly what was written.
          mode_q  <= mode;
          lfsr_sv <= lfsr_q;
          walk_q  <= DW'(1);
          chk_q   <= chk_inv_q ? CHK_B : CHK_A;
          idx_q   <= '0;
        end
        RD_SET: begin
          lfsr_q <= lfsr_sv;
          walk_q <= DW'(1);
          chk_q  <= chk_inv_q ? CHK_B : CHK_A;
          idx_q  <= '0;
        end
        PASS_END: begin
          passcount <= passcount + CNT_W'(1);
          chk_inv_q <= ~chk_inv_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MEMTEST_ERRLOG_EN
  logic              err_valid_q;
  logic [IDX_W-1:0]  err_idx_q;
  logic [DW-1:0]     err_exp_q, err_act_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_idx_q   <= '0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
    end else if (mismatch && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_idx_q   <= idx_q;
      err_exp_q   <= pat;
      err_act_q   <= mem.mem_rdat;
    end
  end

  assign err_valid = err_valid_q;
  assign err_idx   = err_idx_q;
  assign err_exp   = err_exp_q;
  assign err_act   = err_act_q;
`else
  assign err_valid = 1'b0;
  assign err_idx   = '0;
  assign err_exp   = '0;
  assign err_act   = '0;
`endif

endmodule

// File: tb/tb_mem_pattern_tester.sv
`timescale 1ns/1ps
// Bench for mem_pattern_tester: 16-word controller model, table of pass scenarios, reset/saturation sequences.
// Latency: checks sampled 2 ns after each falling edge.
// Backpressure: model can insert idle cycles between beats and merge mem_done onto the last beat.
module tb_mem_pattern_tester;
  localparam int DW = 32, CNT_W = 4, IDX_W = 24, RST_WAIT = 8;
`ifdef MEMTEST_ERRLOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W-1:0] passcount, failcount;
  logic             err_valid;
  logic [IDX_W-1:0] err_idx;
  logic [DW-1:0]    err_exp, err_act;

  mem_pattern_tester_if #(.DW(DW)) ifc();

  mem_pattern_tester #(.DW(DW), .CNT_W(CNT_W), .IDX_W(IDX_W), .RST_WAIT(RST_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mem(ifc),
    .passcount(passcount), .failcount(failcount),
    .err_valid(err_valid), .err_idx(err_idx), .err_exp(err_exp), .err_act(err_act)
  );

  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  bit          flip, gap, merge;
  bit          busy, inited, m_rnw, phase, pend_done, prev_start;
  int          word, init_cnt, wsw, rsw, rd_dones, start_cnt, dbl_start;
  logic [31:0] mem [16];
  logic [31:0] wtr [2][16];
  logic [31:0] rtr [2][16];

  initial begin
    ifc.mem_done = 1'b0; ifc.mem_ready = 1'b0; ifc.mem_rdat = '0;
    forever begin
      @(negedge clk);
      ifc.mem_done = 1'b0;
      ifc.mem_ready = 1'b0;
      if (ifc.mem_start) start_cnt++;
      if (ifc.mem_start && prev_start) dbl_start++;
      prev_start = ifc.mem_start;
      if (pend_done) begin
        ifc.mem_done = 1'b1;
        pend_done = 1'b0;
        if (m_rnw) rd_dones++;
      end
      if (!ifc.mem_rst_n) begin
        busy = 0; inited = 0; init_cnt = 0; wsw = 0; rsw = 0; rd_dones = 0;
        pend_done = 0; dbl_start = 0; ifc.mem_done = 1'b0;
      end else if (!inited) begin
        init_cnt++;
        if (init_cnt == 3) begin
          inited = 1;
          ifc.mem_done = 1'b1;
          ifc.mem_ready = 1'b1;   // stray strobe during INIT must be ignored
        end
      end else if (ifc.mem_start) begin
        busy = 1; m_rnw = ifc.mem_rnw; word = 0; phase = 0;
      end else if (busy) begin
        phase = ~phase;
        if (!gap || phase) begin
          ifc.mem_ready = 1'b1;
          if (m_rnw) begin
            ifc.mem_rdat = mem[word] ^ ((flip && word == 5) ? 32'h1 : 32'h0);
            if (rsw < 2) rtr[rsw][word] = ifc.mem_wdat;
          end else begin
            mem[word] = ifc.mem_wdat;
            if (wsw < 2) wtr[wsw][word] = ifc.mem_wdat;
          end
          if (word == 15) begin
            busy = 0;
            if (m_rnw) rsw++; else wsw++;
            if (merge) begin
              ifc.mem_done = 1'b1;
              if (m_rnw) rd_dones++;
            end else pend_done = 1;
          end
          word++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int passed = 0, total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_reads(input int n, input string name);
    int t;
    t = 0;
    while (rd_dones < n && t < 8000) begin step(); t++; end
    check(name, rd_dones, n);
  endtask

  typedef struct {
    logic [1:0]  mode, mode_b;
    bit          flip, gap, merge;
    int          npass;
    logic [31:0] exp_fail, w0, w1, w3, w15, p1w0, e_exp, e_act;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t, n, s0;
    vt[0] = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3, 32'd0, 32'h1, 32'h8020_0003, 32'h6018_0001,
              32'h6DAD_6D81, 32'hB6F6_B6C3, 32'h0, 32'h0};
    vt[1] = '{2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 3, 32'd3, 32'h0, 32'h1, 32'h3,
              32'hF, 32'h0, 32'h5, 32'h4};
    vt[2] = '{2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 2, 32'd0, 32'h1, 32'h2, 32'h8,
              32'h8000, 32'h0, 32'h0, 32'h0};
    vt[3] = '{2'd3, 2'd3, 1'b0, 1'b0, 1'b1, 2, 32'd0, 32'h5555_5555, 32'hAAAA_AAAA, 32'hAAAA_AAAA,
              32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0, 32'h0};
    vt[4] = '{2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2, 32'd2, 32'h1, 32'h8020_0003, 32'h6018_0001,
              32'h6DAD_6D81, 32'hB6F6_B6C3, 32'hD836_0002, 32'hD836_0003};

    // Reset state, then controller release after RST_WAIT cycles.
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_mem_rst_n", ifc.mem_rst_n, 0);
    check("rst_mem_start", ifc.mem_start, 0);
    check("rst_mem_rnw", ifc.mem_rnw, 0);
    check("rst_mem_wdat", ifc.mem_wdat, 0);
    check("rst_passcount", passcount, 0);
    check("rst_failcount", failcount, 0);
    check("rst_err_valid", err_valid, 0);
    rst_n = 1'b1;
    n = 0;
    while (!ifc.mem_rst_n && n < 100) begin step(); n++; end
    check("hold_cycles", n, RST_WAIT);

    for (int i = 0; i < 5; i++) begin
      flip = vt[i].flip; gap = vt[i].gap; merge = vt[i].merge; mode = vt[i].mode;
      do_reset();
      t = 0;
      while (!busy && t < 200) begin step(); t++; end
      check($sformatf("v%0d_first_sweep", i), busy, 1);
      mode = vt[i].mode_b;
      wait_reads(vt[i].npass, $sformatf("v%0d_read_sweeps", i));
      repeat (3) step();
      check($sformatf("v%0d_passcount", i), passcount, vt[i].npass);
      check($sformatf("v%0d_failcount", i), failcount, vt[i].exp_fail);
      check($sformatf("v%0d_w0", i), wtr[0][0], vt[i].w0);
      check($sformatf("v%0d_w1", i), wtr[0][1], vt[i].w1);
      check($sformatf("v%0d_w3", i), wtr[0][3], vt[i].w3);
      check($sformatf("v%0d_w15", i), wtr[0][15], vt[i].w15);
      check($sformatf("v%0d_r1", i), rtr[0][1], vt[i].w1);
      check($sformatf("v%0d_r15", i), rtr[0][15], vt[i].w15);
      check($sformatf("v%0d_pass1_w0", i), wtr[1][0], vt[i].p1w0);
      check($sformatf("v%0d_start_width", i), dbl_start, 0);
      check($sformatf("v%0d_err_valid", i), err_valid, (LOG_EN && vt[i].flip) ? 1 : 0);
      check($sformatf("v%0d_err_idx", i), err_idx, (LOG_EN && vt[i].flip) ? 5 : 0);
      check($sformatf("v%0d_err_exp", i), err_exp, LOG_EN ? vt[i].e_exp : 32'h0);
      check($sformatf("v%0d_err_act", i), err_act, LOG_EN ? vt[i].e_act : 32'h0);
    end

    // Reset pulse in the middle of the second read sweep.
    flip = 1; gap = 0; merge = 0; mode = 2'd2;
    do_reset();
    wait_reads(1, "mid_first_pass");
    t = 0;
    while (!(busy && m_rnw) && t < 500) begin step(); t++; end
    check("mid_in_read", busy && m_rnw, 1);
    check("mid_failcount_before", failcount, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_hold", ifc.mem_rst_n, 0);
    check("mid_passcount", passcount, 0);
    check("mid_failcount", failcount, 0);
    check("mid_err_valid", err_valid, 0);
    s0 = start_cnt;
    t = 0;
    while (!inited && t < 200) begin step(); t++; end
    check("mid_reinit", inited, 1);
    check("mid_no_start", start_cnt, s0);
    wait_reads(1, "mid_recover");
    repeat (3) step();
    check("mid_rec_passcount", passcount, 1);
    check("mid_rec_failcount", failcount, 1);

    // 16 mismatching passes: passcount wraps to 0, failcount saturates.
    do_reset();
    wait_reads(16, "sat_sweeps");
    repeat (3) step();
    check("sat_passcount_wrap", passcount, 0);
    check("sat_failcount", failcount, 15);
    check("sat_err_idx", err_idx, LOG_EN ? 5 : 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
